// File: rtl/rs_pkg.sv
// Shared widths, micro-op/entry/issue types and the ROB age helper for the
// parametrised reservation-station bank.
package rs_pkg;

   localparam int RS_DEPTH     = 16;
   localparam int RS_DISP_W    = 4;
   localparam int RS_ISS_W     = 4;
   localparam int RS_WB_W      = 4;
   localparam int RS_PRF_W     = 7;
   localparam int RS_ROB_W     = 6;
   localparam int RS_PAYLOAD_W = 64;

   typedef struct packed {
      logic                wrap;
      logic [RS_ROB_W-1:0] idx;
   } rob_t;

   typedef struct packed {
      logic [RS_PRF_W-1:0]     src1_prn;
      logic                    src1_rdy;
      logic [RS_PRF_W-1:0]     src2_prn;
      logic                    src2_rdy;
      logic [RS_PRF_W-1:0]     dest_prn;
      rob_t                    rob;
      logic [RS_ISS_W-1:0]     port_mask;
      logic [RS_PAYLOAD_W-1:0] payload;
   } rs_disp_t;

   typedef struct packed {
      logic [RS_PRF_W-1:0]     dest_prn;
      rob_t                    rob;
      logic [RS_PAYLOAD_W-1:0] payload;
   } rs_iss_t;

   typedef rs_disp_t rs_entry_t;

   // True when a is younger than b; differing wrap bits invert the index order.
   function automatic logic rob_younger(input rob_t a, input rob_t b);
      logic r;
      if (a.wrap != b.wrap) r = (a.idx < b.idx);
      else                  r = (a.idx > b.idx);
      return r;
   endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative dispatch order of bank entries and grants the
// oldest eligible entry to each issue port, lower ports taking first pick.
module rs_age_matrix
   import rs_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int ISS_W = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DEPTH-1:0]            valid_in,
   input  logic [DEPTH-1:0]            alloc_in,
   input  logic [DEPTH-1:0]            free_in,
   input  logic [ISS_W-1:0][DEPTH-1:0] elig_in,
   output logic [ISS_W-1:0][DEPTH-1:0] grant_out
);

   // yng_q[i][j] set means entry i is younger than entry j
   logic [DEPTH-1:0][DEPTH-1:0] yng_q, yng_d;

   // A new entry is younger than every survivor and every lower-slot sibling of its group.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         if (alloc_in[r]) yng_d[r] = (valid_in & ~free_in) | (alloc_in & ((DEPTH'(1) << r) - DEPTH'(1)));
         else             yng_d[r] = yng_q[r] & ~alloc_in & ~free_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) yng_q <= '0;
      else        yng_q <= yng_d;
   end

   always_comb begin : sel
      logic [DEPTH-1:0] taken;
      logic [DEPTH-1:0] avail;
      logic [DEPTH-1:0] g;
      taken = '0;
      for (int p = 0; p < ISS_W; p++) begin
         avail = elig_in[p] & ~taken;
         for (int i = 0; i < DEPTH; i++) g[i] = avail[i] & ((yng_q[i] & avail) == '0);
         grant_out[p] = g;
         taken        = taken | g;
      end
   end

endmodule

// File: rtl/rs_bank_agem.sv
// Reservation-station bank: entry storage, wakeup CAM, free-slot allocation and
// flush/squash kill around an age-matrix oldest-ready selector.
module rs_bank_agem
   import rs_pkg::*;
#(
   parameter int  DEPTH  = RS_DEPTH,
   parameter int  DISP_W = RS_DISP_W,
   parameter int  ISS_W  = RS_ISS_W,
   parameter int  WB_W   = RS_WB_W,
   localparam int CNT_W  = $clog2(DEPTH) + 1,
   localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             pipe_flush,
   input  logic                             squash_valid,
   input  rob_t                             squash_rob,
   input  logic [DISP_W-1:0]                disp_valid,
   input  rs_disp_t [DISP_W-1:0]            disp_pkt,
   output logic [DISP_W-1:0]                disp_ready,
   input  logic [WB_W-1:0]                  wb_valid,
   input  logic [WB_W-1:0][RS_PRF_W-1:0]    wb_prn,
   output logic [ISS_W-1:0]                 iss_valid,
   input  logic [ISS_W-1:0]                 iss_ready,
   output rs_iss_t [ISS_W-1:0]              iss_pkt,
   output logic [CNT_W-1:0]                 free_cnt,
   output logic                             rs_empty
);

   logic [DEPTH-1:0]              valid_q, valid_d;
   rs_entry_t [DEPTH-1:0]         ent_q, ent_d;
   logic [CNT_W-1:0]              free_cnt_q, free_cnt_d;
   logic [DEPTH-1:0]              alloc_s, kill_s, fire_s, ready_s;
   logic [DEPTH-1:0][LANE_W-1:0]  slot_lane_s;
   logic [DISP_W-1:0]             disp_fire_s;
   logic [ISS_W-1:0][DEPTH-1:0]   elig_s, grant_s;

   function automatic logic woken(input logic [RS_PRF_W-1:0] tag,
                                  input logic [WB_W-1:0] v,
                                  input logic [WB_W-1:0][RS_PRF_W-1:0] prn);
      logic hit;
      hit = 1'b0;
      for (int w = 0; w < WB_W; w++) hit = hit | (v[w] & (prn[w] == tag));
      return hit;
   endfunction

   always_comb begin
      for (int k = 0; k < DISP_W; k++)
         disp_ready[k] = (CNT_W'(k) < free_cnt_q) & ~pipe_flush & ~squash_valid;
   end

   assign disp_fire_s = disp_valid & disp_ready;

   // Lane k lands in the k-th lowest slot that was free at the start of the cycle.
   always_comb begin : slot_sel
      int lane;
      lane        = 0;
      alloc_s     = '0;
      slot_lane_s = '0;
      for (int s = 0; s < DEPTH; s++) begin
         if (!valid_q[s] && (lane < DISP_W)) begin
            alloc_s[s]     = disp_fire_s[LANE_W'(lane)];
            slot_lane_s[s] = LANE_W'(lane);
            lane           = lane + 1;
         end else begin
            alloc_s[s] = 1'b0;
         end
      end
   end

   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         kill_s[s]  = valid_q[s] & (pipe_flush | (squash_valid & rob_younger(ent_q[s].rob, squash_rob)));
         ready_s[s] = valid_q[s] & ent_q[s].src1_rdy & ent_q[s].src2_rdy & ~kill_s[s];
         for (int p = 0; p < ISS_W; p++) elig_s[p][s] = ready_s[s] & ent_q[s].port_mask[p];
      end
   end

   rs_age_matrix #(.DEPTH(DEPTH), .ISS_W(ISS_W)) u_age (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_q),
      .alloc_in  (alloc_s),
      .free_in   (fire_s | kill_s),
      .elig_in   (elig_s),
      .grant_out (grant_s)
   );

   // Grants are one-hot, so an AND-OR mux suffices for the issue payload.
   always_comb begin
      fire_s = '0;
      for (int p = 0; p < ISS_W; p++) begin
         iss_valid[p] = |grant_s[p];
         iss_pkt[p]   = '0;
         for (int s = 0; s < DEPTH; s++)
            iss_pkt[p] = iss_pkt[p] | ({$bits(rs_iss_t){grant_s[p][s]}} &
                                       {ent_q[s].dest_prn, ent_q[s].rob, ent_q[s].payload});
         fire_s = fire_s | (grant_s[p] & {DEPTH{iss_ready[p]}});
      end
   end

   always_comb begin
      valid_d = (valid_q & ~fire_s & ~kill_s) | alloc_s;
      for (int s = 0; s < DEPTH; s++) begin
         if (alloc_s[s]) ent_d[s] = disp_pkt[slot_lane_s[s]];
         else            ent_d[s] = ent_q[s];
         ent_d[s].src1_rdy = ent_d[s].src1_rdy | woken(ent_d[s].src1_prn, wb_valid, wb_prn);
         ent_d[s].src2_rdy = ent_d[s].src2_rdy | woken(ent_d[s].src2_prn, wb_valid, wb_prn);
      end
      free_cnt_d = CNT_W'(DEPTH) - CNT_W'($countones(valid_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         ent_q      <= '0;
         free_cnt_q <= CNT_W'(DEPTH);
      end else begin
         valid_q    <= valid_d;
         ent_q      <= ent_d;
         free_cnt_q <= free_cnt_d;
      end
   end

   assign free_cnt = free_cnt_q;
   assign rs_empty = (free_cnt_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_rs_bank_agem.sv
// Self-checking bench for rs_bank_agem: directed scenarios plus a randomized
// run checked against an age-ordered queue model of the bank.
module tb_rs_bank_agem;
   import rs_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   pipe_flush, squash_valid;
   rob_t                   squash_rob;
   logic [3:0]             disp_valid;
   rs_disp_t [3:0]         disp_pkt;
   logic [3:0]             disp_ready;
   logic [3:0]             wb_valid;
   logic [3:0][6:0]        wb_prn;
   logic [3:0]             iss_valid;
   logic [3:0]             iss_ready;
   rs_iss_t [3:0]          iss_pkt;
   logic [4:0]             free_cnt;
   logic                   rs_empty;

   int n_cmp = 0;
   int n_err = 0;

   // Model: queue of live entries, oldest first.
   rs_disp_t   mq[$];
   logic [3:0] exp_disp_ready, exp_iss_valid;
   rs_iss_t    exp_iss_pkt[4];
   int         exp_pick[4];
   logic [4:0] exp_free;
   logic [6:0] rob_ctr;

   always #5 clk = ~clk;

   rs_bank_agem dut (
      .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .squash_valid(squash_valid),
      .squash_rob(squash_rob), .disp_valid(disp_valid), .disp_pkt(disp_pkt),
      .disp_ready(disp_ready), .wb_valid(wb_valid), .wb_prn(wb_prn),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_pkt(iss_pkt),
      .free_cnt(free_cnt), .rs_empty(rs_empty)
   );

   // a younger than b: forward distance from b to a on the 128-entry ROB circle is 1..63
   function automatic bit m_younger(logic [6:0] a, logic [6:0] b);
      logic [6:0] d;
      d = a - b;
      return (d != 7'd0) && (d < 7'd64);
   endfunction

   function automatic bit m_woken(logic [6:0] tag);
      for (int w = 0; w < 4; w++) if (wb_valid[w] && wb_prn[w] == tag) return 1'b1;
      return 1'b0;
   endfunction

   function automatic rs_disp_t mk_pkt(logic [6:0] rob, logic [6:0] p1, logic r1,
                                       logic [6:0] p2, logic r2, logic [3:0] mask);
      rs_disp_t d;
      d.src1_prn  = p1;
      d.src1_rdy  = r1;
      d.src2_prn  = p2;
      d.src2_rdy  = r2;
      d.dest_prn  = 7'($urandom_range(0, 127));
      d.rob       = rob;
      d.port_mask = mask;
      d.payload   = {$urandom(), $urandom()};
      return d;
   endfunction

   task automatic model_expect();
      logic [15:0] taken;
      int          live;
      live     = mq.size();
      exp_free = 5'(16 - live);
      for (int k = 0; k < 4; k++) exp_disp_ready[k] = (k < 16 - live) && !pipe_flush && !squash_valid;
      taken = '0;
      for (int p = 0; p < 4; p++) begin
         exp_iss_valid[p] = 1'b0;
         exp_iss_pkt[p]   = '0;
         exp_pick[p]      = -1;
         for (int i = 0; i < live; i++) begin
            if (!taken[i] && mq[i].src1_rdy && mq[i].src2_rdy && mq[i].port_mask[p] && !pipe_flush &&
                !(squash_valid && m_younger(mq[i].rob, squash_rob))) begin
               taken[i]         = 1'b1;
               exp_iss_valid[p] = 1'b1;
               exp_pick[p]      = i;
               exp_iss_pkt[p]   = '{dest_prn: mq[i].dest_prn, rob: mq[i].rob, payload: mq[i].payload};
               break;
            end
         end
      end
   endtask

   task automatic model_commit();
      rs_disp_t nq[$];
      rs_disp_t e;
      bit       keep;
      for (int i = 0; i < mq.size(); i++) begin
         keep = !pipe_flush && !(squash_valid && m_younger(mq[i].rob, squash_rob));
         for (int p = 0; p < 4; p++) if (exp_pick[p] == i && iss_ready[p]) keep = 0;
         if (keep) begin
            e = mq[i];
            e.src1_rdy = e.src1_rdy | m_woken(e.src1_prn);
            e.src2_rdy = e.src2_rdy | m_woken(e.src2_prn);
            nq.push_back(e);
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (disp_valid[k] && exp_disp_ready[k]) begin
            e = disp_pkt[k];
            e.src1_rdy = e.src1_rdy | m_woken(e.src1_prn);
            e.src2_rdy = e.src2_rdy | m_woken(e.src2_prn);
            nq.push_back(e);
         end
      end
      mq = nq;
   endtask

   task automatic sample();
      @(negedge clk);
      model_expect();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle();
      disp_valid   = '0;
      wb_valid     = '0;
      pipe_flush   = 1'b0;
      squash_valid = 1'b0;
      iss_ready    = '0;
   endtask

   task automatic test_reset();
      sample();
      n_cmp++; if (free_cnt !== 5'd16) begin n_err++; $display("FAIL reset_free_cnt: got %0d want 16", free_cnt); end
      n_cmp++; if (rs_empty !== 1'b1) begin n_err++; $display("FAIL reset_rs_empty: got %b want 1", rs_empty); end
      n_cmp++; if (iss_valid !== 4'b0000) begin n_err++; $display("FAIL reset_iss_valid: got %b want 0000", iss_valid); end
      n_cmp++; if (disp_ready !== 4'b1111) begin n_err++; $display("FAIL reset_disp_ready: got %b want 1111", disp_ready); end
      advance();
   endtask

   task automatic test_basic();
      disp_valid = 4'b1111;
      for (int k = 0; k < 4; k++) disp_pkt[k] = mk_pkt(7'(k), 7'd1, 1'b1, 7'd2, 1'b1, 4'b0001);
      sample();
      n_cmp++; if (disp_ready !== 4'b1111) begin n_err++; $display("FAIL basic_disp_ready: got %b want 1111", disp_ready); end
      advance();
      idle();
      iss_ready = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         sample();
         if (i == 0) begin
            n_cmp++; if (free_cnt !== 5'd12) begin n_err++; $display("FAIL basic_free_cnt: got %0d want 12", free_cnt); end
         end
         n_cmp++;
         if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'(i)) begin
            n_err++; $display("FAIL basic_issue_order: got v=%b rob=%0d want v=1 rob=%0d", iss_valid[0], iss_pkt[0].rob, i);
         end
         advance();
      end
      iss_ready = '0;
      sample();
      n_cmp++; if (rs_empty !== 1'b1) begin n_err++; $display("FAIL basic_drained: got %b want 1", rs_empty); end
      advance();
   endtask

   task automatic test_full();
      for (int g = 0; g < 4; g++) begin
         disp_valid = 4'b1111;
         for (int k = 0; k < 4; k++)
            disp_pkt[k] = mk_pkt(7'(8 + 4 * g + k), 7'd100, (g == 0 && k == 0), 7'd2, 1'b1, 4'b0001);
         sample();
         n_cmp++; if (disp_ready !== 4'b1111) begin n_err++; $display("FAIL full_fill_ready: got %b want 1111", disp_ready); end
         advance();
      end
      idle();
      sample();
      n_cmp++; if (free_cnt !== 5'd0) begin n_err++; $display("FAIL full_free_cnt: got %0d want 0", free_cnt); end
      n_cmp++; if (disp_ready !== 4'b0000) begin n_err++; $display("FAIL full_disp_ready: got %b want 0000", disp_ready); end
      advance();
      iss_ready = 4'b0001;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'd8) begin n_err++; $display("FAIL full_issue: got v=%b rob=%0d want v=1 rob=8", iss_valid[0], iss_pkt[0].rob); end
      advance();
      iss_ready = '0;
      sample();
      n_cmp++; if (free_cnt !== 5'd1) begin n_err++; $display("FAIL full_free_after_issue: got %0d want 1", free_cnt); end
      n_cmp++; if (disp_ready !== 4'b0001) begin n_err++; $display("FAIL full_ready_after_issue: got %b want 0001", disp_ready); end
      advance();
      pipe_flush = 1'b1;
      sample();
      n_cmp++; if (disp_ready !== 4'b0000) begin n_err++; $display("FAIL full_flush_ready: got %b want 0000", disp_ready); end
      advance();
      idle();
      sample();
      n_cmp++; if (rs_empty !== 1'b1) begin n_err++; $display("FAIL full_flush_empty: got %b want 1", rs_empty); end
      advance();
   endtask

   task automatic test_wakeup();
      iss_ready  = 4'b0001;
      disp_valid = 4'b0001;
      disp_pkt[0] = mk_pkt(7'd20, 7'd9, 1'b0, 7'd2, 1'b1, 4'b0001);
      sample(); advance();
      disp_valid = '0;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b0) begin n_err++; $display("FAIL wake_not_ready: got %b want 0", iss_valid[0]); end
      advance();
      wb_valid = 4'b0100; wb_prn = '0; wb_prn[2] = 7'd9;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b0) begin n_err++; $display("FAIL wake_same_cycle: got %b want 0", iss_valid[0]); end
      advance();
      wb_valid = '0;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'd20) begin n_err++; $display("FAIL wake_next_cycle: got v=%b rob=%0d want v=1 rob=20", iss_valid[0], iss_pkt[0].rob); end
      advance();
      disp_valid = 4'b0001;
      disp_pkt[0] = mk_pkt(7'd21, 7'd9, 1'b0, 7'd2, 1'b1, 4'b0001);
      wb_valid = 4'b0100; wb_prn[2] = 7'd9;
      sample(); advance();
      idle(); iss_ready = 4'b0001;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'd21) begin n_err++; $display("FAIL wake_at_dispatch: got v=%b rob=%0d want v=1 rob=21", iss_valid[0], iss_pkt[0].rob); end
      advance();
      idle();
   endtask

   task automatic test_age();
      iss_ready  = 4'b0001;
      disp_valid = 4'b0001;
      disp_pkt[0] = mk_pkt(7'd5, 7'd20, 1'b0, 7'd2, 1'b1, 4'b0001);
      sample(); advance();
      disp_pkt[0] = mk_pkt(7'd3, 7'd1, 1'b1, 7'd2, 1'b1, 4'b0001);
      sample(); advance();
      disp_valid = '0;
      wb_valid = 4'b0001; wb_prn = '0; wb_prn[0] = 7'd20;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'd3) begin n_err++; $display("FAIL age_ready_first: got v=%b rob=%0d want v=1 rob=3", iss_valid[0], iss_pkt[0].rob); end
      advance();
      wb_valid = '0;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'd5) begin n_err++; $display("FAIL age_woken_second: got v=%b rob=%0d want v=1 rob=5", iss_valid[0], iss_pkt[0].rob); end
      advance();
      iss_ready  = '0;
      disp_valid = 4'b0001;
      disp_pkt[0] = mk_pkt(7'd10, 7'd1, 1'b1, 7'd2, 1'b1, 4'b0011);
      sample(); advance();
      disp_valid = 4'b0011;
      disp_pkt[0] = mk_pkt(7'd11, 7'd1, 1'b1, 7'd2, 1'b1, 4'b0011);
      disp_pkt[1] = mk_pkt(7'd12, 7'd1, 1'b1, 7'd2, 1'b1, 4'b0011);
      sample(); advance();
      disp_valid = '0;
      iss_ready  = 4'b0011;
      sample();
      n_cmp++;
      if (iss_valid !== 4'b0011 || iss_pkt[0].rob !== 7'd10 || iss_pkt[1].rob !== 7'd11) begin
         n_err++; $display("FAIL age_two_ports: got v=%b p0=%0d p1=%0d want v=0011 p0=10 p1=11", iss_valid, iss_pkt[0].rob, iss_pkt[1].rob);
      end
      advance();
      sample();
      n_cmp++; if (iss_valid !== 4'b0001 || iss_pkt[0].rob !== 7'd12) begin n_err++; $display("FAIL age_third: got v=%b rob=%0d want v=0001 rob=12", iss_valid, iss_pkt[0].rob); end
      advance();
      idle();
   endtask

   task automatic test_squash_flush();
      disp_valid = 4'b1111;
      for (int k = 0; k < 4; k++) disp_pkt[k] = mk_pkt(7'(60 + k), 7'd30, 1'b0, 7'd2, 1'b1, 4'b0001);
      sample(); advance();
      disp_valid = 4'b0011;
      disp_pkt[0] = mk_pkt(7'd64, 7'd30, 1'b0, 7'd2, 1'b1, 4'b0001);
      disp_pkt[1] = mk_pkt(7'd65, 7'd30, 1'b0, 7'd2, 1'b1, 4'b0001);
      sample(); advance();
      idle();
      squash_valid = 1'b1; squash_rob = 7'd62;
      sample();
      n_cmp++; if (free_cnt !== 5'd10) begin n_err++; $display("FAIL squash_before: got %0d want 10", free_cnt); end
      n_cmp++; if (disp_ready !== 4'b0000) begin n_err++; $display("FAIL squash_disp_ready: got %b want 0000", disp_ready); end
      advance();
      squash_valid = 1'b0;
      wb_valid = 4'b0001; wb_prn = '0; wb_prn[0] = 7'd30;
      sample();
      n_cmp++; if (free_cnt !== 5'd13) begin n_err++; $display("FAIL squash_free_cnt: got %0d want 13", free_cnt); end
      advance();
      wb_valid = '0;
      sample();
      n_cmp++; if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'd60) begin n_err++; $display("FAIL squash_survivor: got v=%b rob=%0d want v=1 rob=60", iss_valid[0], iss_pkt[0].rob); end
      advance();
      pipe_flush = 1'b1; iss_ready = 4'b1111;
      sample();
      n_cmp++; if (iss_valid !== 4'b0000) begin n_err++; $display("FAIL flush_iss_valid: got %b want 0000", iss_valid); end
      advance();
      idle();
      sample();
      n_cmp++; if (rs_empty !== 1'b1 || free_cnt !== 5'd16) begin n_err++; $display("FAIL flush_empty: got empty=%b free=%0d want 1/16", rs_empty, free_cnt); end
      advance();
   endtask

   task automatic test_hold_and_reset();
      disp_valid = 4'b0001;
      disp_pkt[0] = mk_pkt(7'd40, 7'd1, 1'b1, 7'd2, 1'b1, 4'b0001);
      sample(); advance();
      disp_valid = '0;
      for (int c = 0; c < 3; c++) begin
         sample();
         n_cmp++; if (iss_valid[0] !== 1'b1 || iss_pkt[0].rob !== 7'd40) begin n_err++; $display("FAIL hold_cycle%0d: got v=%b rob=%0d want v=1 rob=40", c, iss_valid[0], iss_pkt[0].rob); end
         advance();
      end
      iss_ready = 4'b0001;
      sample(); advance();
      iss_ready = '0;
      sample();
      n_cmp++; if (rs_empty !== 1'b1) begin n_err++; $display("FAIL hold_accepted: got %b want 1", rs_empty); end
      advance();
      disp_valid = 4'b1111;
      for (int k = 0; k < 4; k++) disp_pkt[k] = mk_pkt(7'(41 + k), 7'd1, 1'b1, 7'd2, 1'b1, 4'b0001);
      sample(); advance();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (free_cnt !== 5'd16 || rs_empty !== 1'b1 || iss_valid !== 4'b0000) begin
         n_err++; $display("FAIL async_reset: got free=%0d empty=%b iss=%b want 16/1/0000", free_cnt, rs_empty, iss_valid);
      end
      mq.delete();
      idle();
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int nd, acc;
      for (int cyc = 0; cyc < 500; cyc++) begin
         nd = $urandom_range(0, 4);
         disp_valid = 4'((1 << nd) - 1);
         for (int k = 0; k < 4; k++)
            disp_pkt[k] = mk_pkt(rob_ctr + 7'(k), 7'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                 7'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)));
         for (int w = 0; w < 4; w++) begin
            wb_valid[w] = ($urandom_range(0, 9) < 4);
            wb_prn[w]   = 7'($urandom_range(0, 15));
         end
         iss_ready    = 4'($urandom_range(0, 15));
         pipe_flush   = ($urandom_range(0, 49) == 0);
         squash_valid = !pipe_flush && ($urandom_range(0, 24) == 0);
         squash_rob   = rob_ctr - 7'($urandom_range(1, 16));
         sample();
         n_cmp++; if (disp_ready !== exp_disp_ready) begin n_err++; $display("FAIL rnd_disp_ready c%0d: got %b want %b", cyc, disp_ready, exp_disp_ready); end
         n_cmp++; if (iss_valid !== exp_iss_valid) begin n_err++; $display("FAIL rnd_iss_valid c%0d: got %b want %b", cyc, iss_valid, exp_iss_valid); end
         n_cmp++; if (free_cnt !== exp_free) begin n_err++; $display("FAIL rnd_free_cnt c%0d: got %0d want %0d", cyc, free_cnt, exp_free); end
         n_cmp++; if (rs_empty !== (exp_free == 5'd16)) begin n_err++; $display("FAIL rnd_rs_empty c%0d: got %b want %b", cyc, rs_empty, exp_free == 5'd16); end
         for (int p = 0; p < 4; p++) begin
            if (exp_iss_valid[p]) begin
               n_cmp++;
               if (iss_pkt[p] !== exp_iss_pkt[p]) begin
                  n_err++; $display("FAIL rnd_iss_pkt c%0d p%0d: got rob=%0d dest=%0d want rob=%0d dest=%0d", cyc, p,
                                    iss_pkt[p].rob, iss_pkt[p].dest_prn, exp_iss_pkt[p].rob, exp_iss_pkt[p].dest_prn);
               end
            end
         end
         acc = 0;
         for (int k = 0; k < 4; k++) if (disp_valid[k] && exp_disp_ready[k]) acc++;
         advance();
         rob_ctr = rob_ctr + 7'(acc);
      end
      idle();
   endtask

   initial begin
      rst_n        = 1'b0;
      squash_rob   = '0;
      disp_pkt     = '0;
      wb_prn       = '0;
      rob_ctr      = 7'd70;
      idle();
      #23 rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_full();
      test_wakeup();
      test_age();
      test_squash_flush();
      test_hold_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
